axis_ramp_source: RTL
=====================

// Module: axis_ramp_source
// PURPOSE
//  AXI-Stream master traffic source: on a start pulse it emits one packet of cfg_len beats
//  carrying an arithmetic ramp (init, init+step, ...), with tlast on the final beat.
//  Drives stream pipes and sinks in block benches and on-chip loopback tests.
//  Fully honours downstream backpressure; reports busy/done to a control FSM or CSR block.
// PARAMETERS
//  P_DATA_WIDTH   8        tdata / cfg_init / cfg_step width
//  P_COUNT_WIDTH  16       beat-counter and cfg_len width
//  P_LFSR_SEED    16'hACE1 throttle LFSR reset seed; must be non-zero (used only with macro)
// PORTS
//  clk            in   1              clock
//  rst            in   1              reset, synchronous, active-high
//  start          in   1              start packet; sampled only in IDLE
//  cfg_len        in   P_COUNT_WIDTH  beats per packet; sampled with start
//  cfg_init       in   P_DATA_WIDTH   first beat value; sampled with start
//  cfg_step       in   P_DATA_WIDTH   increment per beat; sampled with start
//  cfg_throttle   in   4              gap threshold; ignored unless macro defined
//  busy           out  1              packet in progress
//  done           out  1              1-cycle pulse at packet end
//  beat_count     out  P_COUNT_WIDTH  beats accepted in current/last packet
//  m_axis_tvalid  out  1              AXIS valid
//  m_axis_tready  in   1              AXIS ready
//  m_axis_tdata   out  P_DATA_WIDTH   AXIS data
//  m_axis_tlast   out  1              AXIS last
// BEHAVIOUR
//  - Reset: state=IDLE; tvalid, tlast, busy, done = 0; tdata = 0; beat_count = 0; LFSR = P_LFSR_SEED.
//  - All outputs registered. Handshake = tvalid & tready on a rising clk edge.
//  - States: IDLE, RUN, GAP (GAP only reachable with macro).
//  - IDLE + start + cfg_len!=0: latch cfg_*; next cycle tvalid=1, tdata=cfg_init,
//    tlast=(cfg_len==1), busy=1, beat_count=0; go to RUN. Latency start->tvalid = 1 cycle.
//  - IDLE + start + cfg_len==0: no beats; done=1 next cycle; stay IDLE; busy stays 0.
//  - RUN, no handshake: tvalid, tdata, tlast held stable (AXIS rule: never retract valid).
//  - RUN, handshake, non-last beat: beat_count+1; tdata += step, modulo 2^P_DATA_WIDTH (wraps
//    silently); tlast=1 iff the next beat is beat cfg_len-1. Full rate: 1 beat/cycle.
//  - RUN, handshake on tlast beat: next cycle tvalid=0, tlast=0, busy=0, done=1 (one cycle);
//    beat_count=cfg_len and holds until next start; go to IDLE.
//  - start while busy: ignored; no effect on the packet in flight or latched config.
//  - start in the done cycle: accepted (state is IDLE) -> back-to-back packets, 1 idle cycle.
//  - cfg_* changes while busy: no effect (latched copies used).
//  - rst mid-packet: all reset values next cycle; packet abandoned, no done pulse.
// CONFIGURATION
//  Macro AXIS_RAMP_SOURCE_THROTTLE_EN:
//  - Defined: 16-bit LFSR steps each cycle. After each non-last handshake in RUN,
//    if lfsr[3:0] < cfg_throttle go to GAP: tvalid=0 for exactly one cycle, then RUN with
//    next beat. cfg_throttle=0 -> never gaps; gaps never inserted before first beat or after tlast.
//  - Undefined: no LFSR, GAP unused, cfg_throttle ignored; back-to-back beats at full rate.
// STRUCTURE
//  - Shared package axis_stream_pkg: state encodings (IDLE/RUN/GAP), LFSR width,
//    LFSR tap polynomial (x^16+x^14+x^13+x^11+1).
//  - One sub-module: axis_lfsr16 (free-running Galois LFSR, seed parameter, en input),
//    instantiated only under AXIS_RAMP_SOURCE_THROTTLE_EN.
// TESTING
//  1. len=4, init=8'h10, step=1, tready=1: beats 10,11,12,13 on consecutive cycles; tlast
//     only on 13; done 1 cycle after; beat_count=4.
//  2. len=6, tready low 3 cycles after beat 2: tvalid/tdata/tlast stable while stalled;
//     all 6 beats delivered in order, none duplicated.
//  3. Wrap: init=8'hFE, step=1, len=4 -> FE,FF,00,01; step=8'h80, len=3 -> FE,7E,FE.
//  4. len=0 + start: done pulses next cycle; tvalid never asserted; busy stays 0.
//  5. rst after 2 of 5 beats: tvalid=0, busy=0 next cycle, no done; new start replays from init.
//  6. start pulsed while busy with different cfg: ignored; with macro, cfg_throttle=0 matches
//     test 1 exactly, cfg_throttle=15 shows single-cycle gaps and no gap after tlast.

Source files
------------

// File: rtl/axis_stream_pkg.sv
// Shared stream-source types: FSM state encoding and throttle LFSR constants.
// LFSR taps realise x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
package axis_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } src_state_e;

  localparam int LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] cur
  );
    logic [LFSR_W-1:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ LFSR_TAPS;
    return nxt;
  endfunction

endpackage

// File: rtl/axis_lfsr16.sv
// Free-running 16-bit Galois LFSR with enable and reset seed.
// Seed must be non-zero or the register locks up at zero.
module axis_lfsr16
  import axis_stream_pkg::*;
#(
  parameter logic [LFSR_W-1:0] P_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= P_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/axis_ramp_source.sv
// AXI-Stream ramp packet source with busy/done status.
// Optional random inter-beat gaps under AXIS_RAMP_SOURCE_THROTTLE_EN.
module axis_ramp_source
  import axis_stream_pkg::*;
#(
  parameter int                P_DATA_WIDTH  = 8,
  parameter int                P_COUNT_WIDTH = 16,
  parameter logic [LFSR_W-1:0] P_LFSR_SEED   = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [P_COUNT_WIDTH-1:0] cfg_len,
  input  logic [P_DATA_WIDTH-1:0]  cfg_init,
  input  logic [P_DATA_WIDTH-1:0]  cfg_step,
  input  logic [3:0]               cfg_throttle,
  output logic                     busy,
  output logic                     done,
  output logic [P_COUNT_WIDTH-1:0] beat_count,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [P_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                     m_axis_tlast
);

  src_state_e state_q, state_d;

  logic [P_COUNT_WIDTH-1:0] len_q, len_d;
  logic [P_COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [P_DATA_WIDTH-1:0]  step_q, step_d;
  logic [P_DATA_WIDTH-1:0]  data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     hs;
  logic                     gap_hit;
  logic [P_COUNT_WIDTH-1:0] cnt_inc;

`ifdef AXIS_RAMP_SOURCE_THROTTLE_EN
  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr;

  axis_lfsr16 #(
    .P_SEED (P_LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .lfsr (lfsr)
  );

  assign gap_hit     = lfsr[3:0] < cfg_throttle;
  assign unused_lfsr = ^lfsr[LFSR_W-1:4];
`else
  logic unused_throttle;

  assign gap_hit         = 1'b0;
  assign unused_throttle = ^{cfg_throttle, P_LFSR_SEED};
`endif

  assign hs      = valid_q & m_axis_tready;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (cfg_len != '0) begin
            len_d   = cfg_len;
            step_d  = cfg_step;
            data_d  = cfg_init;
            valid_d = 1'b1;
            last_d  = (cfg_len == P_COUNT_WIDTH'(1));
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (hs) begin
          cnt_d = cnt_inc;
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            data_d = data_q + step_q;
            // next beat is the final one when it is index len-1
            last_d = (cnt_inc == len_q - 1'b1);
            if (gap_hit) begin
              valid_d = 1'b0;
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        valid_d = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign beat_count    = cnt_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tlast  = last_q;

endmodule
